// File: rtl/sr595_chain_driver_pkg.sv
// Shared definitions for the 74HC595 chain driver: frame-sequencer state
// encodings and a counter width helper.
package sr595_chain_driver_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SH_LO = 3'd2;
  localparam logic [2:0] S_SH_HI = 3'd3;
  localparam logic [2:0] S_LT_HI = 3'd4;
  localparam logic [2:0] S_LT_LO = 3'd5;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Half-phase timer: a down-counter reloaded with HALF_PERIOD-1 on start and
// on every terminal count, so consecutive phases chain without gaps.
module sr_phase_timer
  import sr595_chain_driver_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tick
);

  localparam int CW = cnt_width(HALF_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  // Count down to zero, then reload for the next phase.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sr595_chain_driver.sv
// Serialises one frame into a 74HC595 daisy-chain (DS/SHCP/STCP/MR_n/OE_n).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting; accepts a frame or starts a pending clear
// S_CLR   | mr_n low for one half-phase (commanded or auto clear)
// S_SH_LO | ds presents the current bit, shcp low
// S_SH_HI | shcp high, ds held
// S_LT_HI | stcp high, latches the shift register
// S_LT_LO | stcp low; oe_n enabled on exit
module sr595_chain_driver
  import sr595_chain_driver_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 1,
  parameter bit MSB_FIRST   = 1'b0,
  parameter bit AUTO_CLEAR  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              clear_req,
  output logic              ds,
  output logic              shcp,
  output logic              stcp,
  output logic              mr_n,
  output logic              oe_n,
  output logic              busy,
  output logic              done
);

  localparam int IW = cnt_width(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     bit_idx, idx_nxt;
  logic [DATA_W-1:0] data_q, data_nxt, data_ord;
  logic              clear_pend, clr_only;
  logic              accept, start, tick, frame_end;

  // A clear request arriving in the same cycle as a load must win, so the
  // raw request also blocks ready before it has been registered.
  assign load_ready = (state == S_IDLE) && !clear_pend && !clear_req;
  assign accept     = load_valid && load_ready;
  assign start      = (state == S_IDLE) && (clear_pend || accept);
  assign frame_end  = (state == S_LT_LO) && tick;

  sr_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .tick  (tick)
  );

  // Bit order is resolved once here so the shifter always walks index 0 up.
  for (genvar i = 0; i < DATA_W; i++) begin : g_ord
    assign data_ord[i] = MSB_FIRST ? data_nxt[DATA_W-1-i] : data_nxt[i];
  end

  // Next-state, next bit index and data capture.
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    data_nxt  = data_q;
    case (state)
      S_IDLE: begin
        if (clear_pend) begin
          state_nxt = S_CLR;
        end else if (accept) begin
          state_nxt = AUTO_CLEAR ? S_CLR : S_SH_LO;
          data_nxt  = load_data;
          idx_nxt   = '0;
        end
      end
      S_CLR:   if (tick) state_nxt = clr_only ? S_LT_HI : S_SH_LO;
      S_SH_LO: if (tick) state_nxt = S_SH_HI;
      S_SH_HI: begin
        // The last bit leaves bit_idx alone so it never overflows its width.
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = S_LT_HI;
          end else begin
            state_nxt = S_SH_LO;
            idx_nxt   = bit_idx + IW'(1);
          end
        end
      end
      S_LT_HI: if (tick) state_nxt = S_LT_LO;
      S_LT_LO: if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state, capture register and pending-clear bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      data_q     <= '0;
      clear_pend <= 1'b0;
      clr_only   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
      data_q  <= data_nxt;
      if (state == S_IDLE && clear_pend) begin
        clr_only <= 1'b1;
      end else if (accept) begin
        clr_only <= 1'b0;
      end
      if (clear_req) begin
        clear_pend <= 1'b1;
      end else if (state == S_IDLE && clear_pend) begin
        clear_pend <= 1'b0;
      end
    end
  end

  // Pin outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds   <= 1'b0;
      shcp <= 1'b0;
      stcp <= 1'b0;
      mr_n <= 1'b0;
      oe_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      shcp <= (state_nxt == S_SH_HI);
      stcp <= (state_nxt == S_LT_HI);
      mr_n <= (state_nxt != S_CLR);
      busy <= (state_nxt != S_IDLE);
      done <= frame_end;
      if (frame_end) oe_n <= 1'b0;
      if (state_nxt == S_SH_LO) ds <= data_ord[idx_nxt];
    end
  end

endmodule

// File: tb/tb_sr595_chain_driver.sv
// Bench for sr595_chain_driver: three instances with different parameters,
// checked against a behavioural model of the physical 74HC595 chain.
module tb_sr595_chain_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [2:0]  lv, clr, rdy, ds, shcp, stcp, mr_n, oe_n, busy, done;
  logic [15:0] ld [3];

  int n_tests = 0;
  int n_fail  = 0;

  sr595_chain_driver #(.DATA_W(8), .HALF_PERIOD(1), .MSB_FIRST(1'b0), .AUTO_CLEAR(1'b0)) u_a (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0][7:0]), .load_ready(rdy[0]),
    .clear_req(clr[0]), .ds(ds[0]), .shcp(shcp[0]), .stcp(stcp[0]), .mr_n(mr_n[0]),
    .oe_n(oe_n[0]), .busy(busy[0]), .done(done[0]));

  sr595_chain_driver #(.DATA_W(16), .HALF_PERIOD(3), .MSB_FIRST(1'b1), .AUTO_CLEAR(1'b0)) u_b (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy[1]),
    .clear_req(clr[1]), .ds(ds[1]), .shcp(shcp[1]), .stcp(stcp[1]), .mr_n(mr_n[1]),
    .oe_n(oe_n[1]), .busy(busy[1]), .done(done[1]));

  sr595_chain_driver #(.DATA_W(4), .HALF_PERIOD(2), .MSB_FIRST(1'b0), .AUTO_CLEAR(1'b1)) u_c (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2][3:0]), .load_ready(rdy[2]),
    .clear_req(clr[2]), .ds(ds[2]), .shcp(shcp[2]), .stcp(stcp[2]), .mr_n(mr_n[2]),
    .oe_n(oe_n[2]), .busy(busy[2]), .done(done[2]));

  function automatic int w_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 4;
  endfunction
  function automatic int h_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction
  function automatic int msb_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int ac_of(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic logic [15:0] mask_of(input int k);
    return 16'((32'd1 << w_of(k)) - 1);
  endfunction

  // Chain contents after a frame: the first bit shifted ends at Q[W-1].
  function automatic logic [15:0] exp_store(input int k, input logic [15:0] d);
    logic [15:0] m, r;
    m = d & mask_of(k);
    if (msb_of(k) == 1) return m;
    r = '0;
    for (int i = 0; i < w_of(k); i++) r[w_of(k)-1-i] = m[i];
    return r;
  endfunction

  function automatic int latency(input int k);
    return 1 + (2 * w_of(k) + 2 + ac_of(k)) * h_of(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Physical chain model plus shcp level-length checks.
  logic [15:0] sreg [3];
  logic [15:0] store [3];
  logic [2:0]  shcp_q, stcp_q;
  int          hi_run [3], lo_run [3], sh_rises [3], st_rises [3], mr_lo [3];
  bit          lo_ok [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!mr_n[k]) begin
        sreg[k] = '0;
        if (busy[k]) mr_lo[k]++;
      end
      if (shcp[k] && !shcp_q[k]) begin
        if (mr_n[k]) sreg[k] = ((sreg[k] << 1) | 16'(ds[k])) & mask_of(k);
        sh_rises[k]++;
        if (lo_ok[k]) chk("shcp_lo_len", lo_run[k], h_of(k));
        hi_run[k] = 0;
      end
      if (!shcp[k] && shcp_q[k]) begin
        chk("shcp_hi_len", hi_run[k], h_of(k));
        lo_ok[k]  = 1'b1;
        lo_run[k] = 0;
      end
      if (shcp[k]) hi_run[k]++; else lo_run[k]++;
      if (stcp[k] && !stcp_q[k]) begin
        store[k] = sreg[k];
        st_rises[k]++;
        lo_ok[k] = 1'b0;
      end
      if (reset) lo_ok[k] = 1'b0;
      shcp_q[k] = shcp[k];
      stcp_q[k] = stcp[k];
    end
  end

  // Present a frame from a negedge until accepted; returns the accept cycle.
  task automatic send(input int k, input logic [15:0] d, input bit keep, output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    ld[k] = d;
    lv[k] = 1'b1;
    for (int i = 0; i < 600 && !got; i++) begin
      #1;
      if (rdy[k]) begin
        got   = 1'b1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    if (!keep) lv[k] = 1'b0;
    ld[k] = 16'($urandom);
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int k, output int t);
    t = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done[k]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic frame(input int k, input logic [15:0] d, input bit keep,
                       input int exp_acc, output int td);
    int ta, st0, mr0;
    st0 = st_rises[k];
    mr0 = mr_lo[k];
    send(k, d, keep, ta);
    if (exp_acc >= 0) chk("accept_on_done", ta, exp_acc);
    wait_done(k, td);
    chk("frame_latency", td - ta, latency(k));
    chk("latched_frame", 32'(store[k]), 32'(exp_store(k, d)));
    chk("stcp_pulses", st_rises[k] - st0, 1);
    chk("mr_low_cycles", mr_lo[k] - mr0, ac_of(k) * h_of(k));
    chk("oe_n_after", 32'(oe_n[k]), 0);
  endtask

  initial begin
    int td, tc, base, st0, mr0;
    logic [15:0] d;
    reset = 1'b1;
    lv = '0;
    clr = '0;
    shcp_q = '0;
    stcp_q = '0;
    for (int k = 0; k < 3; k++) begin
      ld[k] = '0; sreg[k] = '0; store[k] = '0; hi_run[k] = 0; lo_run[k] = 0;
      sh_rises[k] = 0; st_rises[k] = 0; mr_lo[k] = 0; lo_ok[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_outs", 32'({ds[k], shcp[k], stcp[k], mr_n[k], oe_n[k], busy[k], done[k]}), 32'h04);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("idle_mr_n", 32'(mr_n[k]), 1);
      chk("idle_ready", 32'(rdy[k]), 1);
    end

    // Instance A: 8 bits, LSB first, one-cycle phases.
    chk("oe_n_before", 32'(oe_n[0]), 1);
    frame(0, 16'h00A5, 1'b0, -1, td);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      frame(0, 16'($urandom), 1'b0, -1, td);
    end

    // Clear requested five cycles into a frame.
    d = 16'($urandom);
    send(0, d, 1'b0, tc);
    repeat (4) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    st0 = st_rises[0];
    mr0 = mr_lo[0];
    wait_done(0, td);
    chk("frame_latency_clr", td - tc, latency(0));
    chk("latched_before_clr", 32'(store[0]), 32'(exp_store(0, d)));
    chk("ready_clear_pend", 32'(rdy[0]), 0);
    tc = td;
    wait_done(0, td);
    chk("clear_latency_busy", td - tc, 1 + 3 * h_of(0));
    chk("cleared", 32'(store[0]), 0);
    chk("clear_mr_low", mr_lo[0] - mr0, h_of(0));
    chk("clear_stcp", st_rises[0] - st0, 2);

    // Clear and load in the same idle cycle: clear first, load on its done.
    repeat (2) @(negedge clk);
    frame(0, 16'h00FF, 1'b0, -1, td);
    d = 16'($urandom);
    clr[0] = 1'b1;
    lv[0] = 1'b1;
    ld[0] = d;
    #1;
    chk("ready_on_clear", 32'(rdy[0]), 0);
    tc = cyc;
    @(negedge clk);
    clr[0] = 1'b0;
    wait_done(0, td);
    chk("clear_latency_idle", td - tc, 2 + 3 * h_of(0));
    chk("cleared_idle", 32'(store[0]), 0);
    chk("ready_in_done", 32'(rdy[0]), 1);
    tc = td;
    @(negedge clk);
    lv[0] = 1'b0;
    ld[0] = 16'($urandom);
    wait_done(0, td);
    chk("frame_after_clear", td - tc, latency(0));
    chk("latched_after_clear", 32'(store[0]), 32'(exp_store(0, d)));

    // Reset while shifting bit 4.
    send(0, 16'h003C, 1'b0, tc);
    base = sh_rises[0];
    st0 = st_rises[0];
    for (int i = 0; i < 50 && sh_rises[0] - base < 4; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outs", 32'({ds[0], shcp[0], stcp[0], mr_n[0], oe_n[0], busy[0], done[0]}), 32'h04);
    chk("reset_no_latch", st_rises[0] - st0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_no_latch_late", st_rises[0] - st0, 0);
    chk("oe_n_after_reset", 32'(oe_n[0]), 1);
    frame(0, 16'h00FF, 1'b0, -1, td);

    // Instance B: 16 bits, MSB first, three-cycle phases.
    frame(1, 16'h8001, 1'b0, -1, td);
    for (int i = 0; i < 3; i++) frame(1, 16'($urandom), 1'b0, -1, td);

    // Instance C: auto-clear, back-to-back with load_valid held high.
    frame(2, 16'($urandom), 1'b1, -1, td);
    for (int i = 1; i < 4; i++) begin
      tc = td;
      frame(2, 16'($urandom), (i < 3), tc, td);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
